// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: EX/WB pipe view and illegal-trace-buffer entry types.
package cv32e40x_pkg;

    localparam int ILT_SEQ_W = 16;

    typedef struct packed {
        logic [31:0] rdata;
    } obi_inst_resp_t;

    typedef struct packed {
        obi_inst_resp_t bus_resp;
    } inst_resp_t;

    typedef struct packed {
        logic        instr_valid;
        logic        illegal_insn;
        logic [31:0] pc;
        inst_resp_t  instr;
    } ex_wb_pipe_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [ILT_SEQ_W-1:0] seq;
    } ilt_entry_t;

endpackage

// File: rtl/cv32e40x_ilt_fifo.sv
// cv32e40x_ilt_fifo: DEPTH-entry register FIFO with occupancy counter; head reads zero when empty.
module cv32e40x_ilt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 80
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/cv32e40x_illegal_trace_buffer.sv
// cv32e40x_illegal_trace_buffer: captures illegal instructions leaving WB into a FIFO with retire/drop counters.
// Define CV32E40X_ILLEGAL_TRACE_LOG_EN to print capture and drop messages in simulation.
module cv32e40x_illegal_trace_buffer
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  ex_wb_pipe_t            ex_wb_pipe_i,
    input  logic                   wb_valid_i,
    input  logic [31:0]            mhartid_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output ilt_entry_t             rd_entry_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [7:0]             drop_cnt_o,
    output logic [SEQ_W-1:0]       retire_cnt_o
);

    if (SEQ_W != ILT_SEQ_W) begin : g_seq_w_check
        $error("SEQ_W must equal ILT_SEQ_W");
    end

    logic       ret;
    logic       cap;
    logic       pop;
    logic       push;
    logic       full;
    logic       empty;
    logic       unused_hartid;
    ilt_entry_t new_entry;

    assign ret  = wb_valid_i && ex_wb_pipe_i.instr_valid;
    assign cap  = ret && ex_wb_pipe_i.illegal_insn;
    assign pop  = rd_valid_o && rd_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push = cap && (!full || pop);
    assign rd_valid_o = !empty;
    assign unused_hartid = ^mhartid_i;

    assign new_entry = '{pc: ex_wb_pipe_i.pc, instr: ex_wb_pipe_i.instr.bus_resp.rdata, seq: retire_cnt_o};

    cv32e40x_ilt_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ilt_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (new_entry),
        .rdata (rd_entry_o),
        .count (count_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_o <= '0;
            drop_cnt_o   <= '0;
        end else begin
            if (ret) retire_cnt_o <= retire_cnt_o + SEQ_W'(1);
            if (cap && !push && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

`ifdef CV32E40X_ILLEGAL_TRACE_LOG_EN
`ifndef FORMAL
    always_ff @(posedge clk) begin
        if (rst_n && push)
            $display("%t: Illegal insn captured (core %0d) PC 0x%h seq %0d",
                     $time, mhartid_i[3:0], ex_wb_pipe_i.pc, retire_cnt_o);
        if (rst_n && cap && !push)
            $display("%t: Warning: illegal insn dropped, trace buffer full (core %0d) drop_cnt %0d",
                     $time, mhartid_i[3:0], drop_cnt_o);
    end
`endif
`endif

endmodule

// File: tb/tb_cv32e40x_illegal_trace_buffer.sv
// tb_cv32e40x_illegal_trace_buffer: directed + randomized checks against a queue-based reference model.
module tb_cv32e40x_illegal_trace_buffer;
    import cv32e40x_pkg::*;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 16;

    logic        clk = 0;
    logic        rst_n = 0;
    ex_wb_pipe_t pipe = '0;
    logic        wb_valid = 0;
    logic [31:0] mhartid = 32'd3;
    logic        rd_valid;
    logic        rd_ready = 0;
    ilt_entry_t  rd_entry;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;
    logic [15:0] retire_cnt;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    cv32e40x_illegal_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_wb_pipe_i (pipe),
        .wb_valid_i   (wb_valid),
        .mhartid_i    (mhartid),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rd_ready),
        .rd_entry_o   (rd_entry),
        .count_o      (count),
        .drop_cnt_o   (drop_cnt),
        .retire_cnt_o (retire_cnt)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of captured entries plus plain integer counters
    ilt_entry_t mq[$];
    int m_drop;
    int m_ret;
    bit m_retev, m_cap, m_pop;
    ilt_entry_t m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
            m_ret = 0;
        end else begin
            m_retev = wb_valid && pipe.instr_valid;
            m_cap = m_retev && pipe.illegal_insn;
            m_pop = mq.size() > 0 && rd_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_cap) begin
                m_e.pc = pipe.pc;
                m_e.instr = pipe.instr.bus_resp.rdata;
                m_e.seq = 16'(m_ret);
                if (mq.size() < DEPTH) mq.push_back(m_e);
                else if (m_drop < 255) m_drop++;
            end
            if (m_retev) m_ret = (m_ret + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 80'(rd_valid), 80'(mq.size() > 0));
        chk("model_entry", rd_entry, mq.size() > 0 ? mq[0] : 80'd0);
        chk("model_count", 80'(count), 80'(mq.size()));
        chk("model_drop", 80'(drop_cnt), 80'(m_drop));
        chk("model_retire", 80'(retire_cnt), 80'(m_ret));
    end

    task automatic step(input bit iv, input bit ill, input bit wb, input logic [31:0] pc,
                        input logic [31:0] ins, input bit rdy);
        pipe.instr_valid = iv;
        pipe.illegal_insn = ill;
        pipe.pc = pc;
        pipe.instr.bus_resp.rdata = ins;
        wb_valid = wb;
        rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && count != 0; i++) step(0, 0, 0, 0, 0, 1);
        chk("drain_empty", 80'(count), 80'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(0, 0, 0, 0, 0, 0);
        rst_n = 1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        chk("rst_valid", 80'(rd_valid), 80'd0);
        chk("rst_entry", rd_entry, 80'd0);
        chk("rst_count", 80'(count), 80'd0);
        chk("rst_drop", 80'(drop_cnt), 80'd0);
        chk("rst_retire", 80'(retire_cnt), 80'd0);
        rst_n = 1;

        repeat (3) step(1, 0, 1, 32'h40, 32'h13, 0);
        step(1, 1, 1, 32'h100, 32'hFFFF_FFFF, 0);
        chk("first_valid", 80'(rd_valid), 80'd1);
        chk("first_entry", rd_entry, {32'h100, 32'hFFFF_FFFF, 16'd3});
        chk("first_count", 80'(count), 80'd1);
        chk("first_retire", 80'(retire_cnt), 80'd4);
        drain();

        repeat (5) step(1, 1, 0, 32'h180, 32'h0, 0);
        step(1, 1, 1, 32'h180, 32'h0, 0);
        chk("stall_count", 80'(count), 80'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("stall_still_one", 80'(count), 80'd1);
        drain();

        for (int i = 0; i < DEPTH + 2; i++) step(1, 1, 1, 32'h200 + 32'(4 * i), 32'hdead_0000 + 32'(i), 0);
        chk("over_count", 80'(count), 80'd4);
        chk("over_drop", 80'(drop_cnt), 80'd2);
        for (int i = 0; i < DEPTH; i++) begin
            chk("over_order", 80'(rd_entry.pc), 80'(32'h200 + 32'(4 * i)));
            step(0, 0, 0, 0, 0, 1);
        end
        chk("over_empty", 80'(count), 80'd0);

        for (int i = 0; i < DEPTH; i++) step(1, 1, 1, 32'h300 + 32'(4 * i), 32'h0, 0);
        step(1, 1, 1, 32'h400, 32'h1234_5678, 1);
        chk("fullpop_count", 80'(count), 80'd4);
        chk("fullpop_drop", 80'(drop_cnt), 80'd2);
        chk("fullpop_head", 80'(rd_entry.pc), 80'h304);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        chk("fullpop_tail", 80'(rd_entry.pc), 80'h400);
        drain();

        do_reset();
        repeat (65535) step(1, 0, 1, 32'h44, 32'h13, 0);
        chk("wrap_pre", 80'(retire_cnt), 80'hFFFF);
        step(1, 1, 1, 32'h500, 32'h0000_0000, 0);
        chk("wrap_seq", 80'(rd_entry.seq), 80'hFFFF);
        chk("wrap_retire", 80'(retire_cnt), 80'd0);
        drain();

        do_reset();
        for (int i = 0; i < DEPTH + 5; i++) step(1, 1, 1, 32'h600 + 32'(4 * i), 32'h0, 0);
        chk("mid_drop", 80'(drop_cnt), 80'd5);
        step(0, 0, 0, 0, 0, 1);
        chk("mid_count", 80'(count), 80'd3);
        rst_n = 0;
        #1;
        chk("async_valid", 80'(rd_valid), 80'd0);
        chk("async_entry", rd_entry, 80'd0);
        chk("async_count", 80'(count), 80'd0);
        chk("async_drop", 80'(drop_cnt), 80'd0);
        chk("async_retire", 80'(retire_cnt), 80'd0);
        step(0, 0, 0, 0, 0, 0);
        rst_n = 1;

        repeat (3000)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 $urandom, $urandom, $urandom_range(0, 1) == 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cv32e40x_illegal_trace_buffer.md
# cv32e40x_illegal_trace_buffer

Writeback-side capture buffer for illegal instructions. Sits downstream of the EX/WB pipeline register, alongside the core logger. Records the PC, instruction word and retire sequence number of every illegal instruction that leaves WB into a small FIFO, drained by a valid/ready read port (debug/trace readout). Also keeps a retire counter and a saturating drop counter.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SEQ_W, 16, width of retire sequence counter and stored sequence field.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_wb_pipe_i  input  ex_wb_pipe_t  EX/WB pipe; uses instr_valid, illegal_insn, pc, instr.bus_resp.rdata.
- wb_valid_i  input  1  instruction in WB completes this cycle (one pulse per instruction).
- mhartid_i  input  32  hart id, used only for logging.
- rd_valid_o  output  1  head entry available.
- rd_ready_i  input  1  consumer accepts head entry.
- rd_entry_o  output  ilt_entry_t  head entry {pc[31:0], instr[31:0], seq[SEQ_W-1:0]}.
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  output  8  entries lost to full FIFO, saturating at 255.
- retire_cnt_o  output  SEQ_W  instructions retired since reset, wraps.

## Operation
- Retire event: ret = wb_valid_i && ex_wb_pipe_i.instr_valid. retire_cnt increments by 1 per ret, wraps 2^SEQ_W-1 -> 0.
- Capture event: cap = ret && ex_wb_pipe_i.illegal_insn. A stalled instruction (instr_valid=1, wb_valid_i=0) is never captured, so no duplicates.
- Entry seq = retire_cnt value before this cycle's increment (first retired instruction has seq 0).
- Pop: pop = rd_valid_o && rd_ready_i.
- Push accepted when cap && (count < DEPTH || pop). Full with cap and no pop: entry discarded, drop_cnt += 1 (saturate at 255); FIFO content unchanged.
- Simultaneous push and pop: count unchanged. When count==1, the head is replaced by the new entry next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is held in a separate counter; no pointer-extension trick.
- rd_entry_o is a combinational read of the head storage register. It is X-free (zero) when empty.
- No internal state machine beyond FIFO EMPTY / PARTIAL / FULL, derived from count: EMPTY(0), FULL(DEPTH), else PARTIAL.

## Timing
- Reset values: rd_valid_o=0, rd_entry_o=0, count_o=0, drop_cnt_o=0, retire_cnt_o=0; storage cleared.
- Capture latency: cap in cycle N -> entry visible at head (if FIFO was empty) and rd_valid_o=1 in cycle N+1.
- count_o, drop_cnt_o and retire_cnt_o are registered; each updates the cycle after the event.
- rd_valid_o depends only on registered state, never combinationally on rd_ready_i or cap.
- Reset asserted mid-operation: all state clears immediately (async). No entry survives.

## Configuration
- CV32E40X_ILLEGAL_TRACE_LOG_EN defined (and FORMAL not defined): on each accepted push, the block prints `$display("%t: Illegal insn captured (core %0d) PC 0x%h seq %0d")` using mhartid_i[3:0]. On each drop, it prints a warning that includes drop_cnt.
- Macro undefined: no display statements. Functional behaviour is identical in both cases.

## Structure
- cv32e40x_pkg: ilt_entry_t packed struct {pc, instr, seq}. SEQ_W stays a parameter, so seq is sized via a package localparam ILT_SEQ_W=16, and the module asserts SEQ_W==ILT_SEQ_W.
- Sub-module cv32e40x_ilt_fifo: generic DEPTH-entry register FIFO with push/pop, count and full/empty outputs. Parent owns the event decode, the counters and logging.

## Test plan
- Reset, then one illegal instruction at pc=0x0000_0100, instr=0xFFFF_FFFF, with wb_valid_i=1 after 3 legal retires. Required: next cycle rd_valid_o=1, entry {0x100, 0xFFFFFFFF, seq=3}, count_o=1, retire_cnt_o=4.
- Illegal instruction stalled in WB for 5 cycles (instr_valid=1, wb_valid_i=0), then completing. Required: exactly one entry; count_o=1.
- Capture DEPTH+2=6 illegal instructions with rd_ready_i=0. Required: count_o=4, drop_cnt_o=2; drained entries are the first 4 in order.
- FIFO full with rd_ready_i=1 and cap in the same cycle. Required: count_o stays 4, drop_cnt_o unchanged, new entry appears at the tail.
- retire_cnt preloaded by 65535 legal retires, then an illegal retire. Required: entry seq=0xFFFF, retire_cnt_o wraps to 0.
- Assert rst_n low for 1 cycle with 3 entries queued and drop_cnt_o=5. Required: all outputs return to reset values in the same cycle rst_n falls.
